// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the synchronised serial line / frame configuration
// and the UART receive controller.
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      rx_in;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [3:0]                data_bits;
  logic                      par_en;
  logic                      par_typ;
  logic                      two_stop;
  logic [DATA_WIDTH-1:0]     rx_data;
  logic                      data_valid;
  logic                      par_err;
  logic                      stp_err;
  logic                      busy;

  modport master (
    output rx_in, prescale, data_bits, par_en, par_typ, two_stop,
    input  rx_data, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  rx_in, prescale, data_bits, par_en, par_typ, two_stop,
    output rx_data, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled start detection, 2-of-3 majority bit
// sampling, runtime frame format (5..DATA_WIDTH bits, parity, 1/2 stop bits).
module uart_rx_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_rx_ctrl_if.slave bus
);

  localparam int                  PW           = PRESCALE_WIDTH;
  localparam logic [3:0]          MAX_BITS     = 4'(DATA_WIDTH);
  localparam logic [3:0]          MIN_BITS     = 4'd5;
  localparam logic [PW-1:0]       MIN_PRESCALE = PW'(6);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] v, input logic odd);
    return (^v) ^ odd;
  endfunction

  state_e                  state_q, state_d;
  logic                    armed_q, armed_d;
  logic [PW-1:0]           edge_q, edge_d;
  logic [3:0]              bit_q, bit_d;
  logic [1:0]              samp_q, samp_d;
  logic                    vote_q, vote_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [3:0]              nbits_q, nbits_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    two_stop_q, two_stop_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    perr_q, perr_d;
  logic                    serr_q, serr_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;
  logic                    busy_q, busy_d;

  logic [PW-1:0]           half_s;
  logic [PW-1:0]           sample_lo_s;
  logic [PW-1:0]           sample_hi_s;
  logic [PW-1:0]           decide_pt_s;
  logic                    wrap_s;
  logic                    decide_s;
  logic [3:0]              last_bit_s;
  logic                    vote_now_s;
  logic                    frame_end_s;

  // The vote is formed in the last sample cycle so that the decision cycle
  // (half+2) can act on a registered value and frame-end pulses appear there.
  assign half_s      = presc_q >> 1;
  assign sample_lo_s = half_s - PW'(1);
  assign sample_hi_s = half_s + PW'(1);
  assign decide_pt_s = half_s + PW'(2);
  assign wrap_s      = (edge_q == (presc_q - PW'(1)));
  assign decide_s    = (edge_q == decide_pt_s);
  assign last_bit_s  = nbits_q + {3'b000, par_en_q} + 4'd1 + {3'b000, two_stop_q};
  assign vote_now_s  = majority3(samp_q[0], samp_q[1], bus.rx_in);
  assign frame_end_s = (state_q == STOP) && (bit_q == last_bit_s) && (edge_q == sample_hi_s);

  // Next-state, counters, sampler, deserialiser and frame-end pulse logic
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    edge_d       = edge_q;
    bit_d        = bit_q;
    samp_d       = samp_q;
    vote_d       = vote_q;
    presc_d      = presc_q;
    nbits_d      = nbits_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    two_stop_d   = two_stop_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    serr_d       = serr_q;
    rx_data_d    = rx_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    if (state_q == IDLE) begin
      if (bus.rx_in) begin
        armed_d = 1'b1;
      end else if (armed_q) begin
        state_d    = START;
        armed_d    = 1'b0;
        edge_d     = '0;
        bit_d      = 4'd0;
        samp_d     = 2'b00;
        vote_d     = 1'b0;
        presc_d    = (bus.prescale < MIN_PRESCALE) ? MIN_PRESCALE : bus.prescale;
        if (bus.data_bits < MIN_BITS) begin
          nbits_d = MIN_BITS;
        end else if (bus.data_bits > MAX_BITS) begin
          nbits_d = MAX_BITS;
        end else begin
          nbits_d = bus.data_bits;
        end
        par_en_d   = bus.par_en;
        par_typ_d  = bus.par_typ;
        two_stop_d = bus.two_stop;
        shift_d    = '0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;
      end else begin
        armed_d = 1'b0;
      end
    end else begin
      if (wrap_s) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + PW'(1);
      end

      if (edge_q == sample_lo_s) begin
        samp_d[0] = bus.rx_in;
      end else if (edge_q == half_s) begin
        samp_d[1] = bus.rx_in;
      end else if (edge_q == sample_hi_s) begin
        vote_d = vote_now_s;
      end else begin
        vote_d = vote_q;
      end

      if (frame_end_s) begin
        par_err_d = perr_q;
        stp_err_d = serr_q | ~vote_now_s;
        if (!perr_q && !serr_q && vote_now_s) begin
          rx_data_d    = shift_q;
          data_valid_d = 1'b1;
        end else begin
          rx_data_d = rx_data_q;
        end
      end else begin
        par_err_d = 1'b0;
      end

      case (state_q)
        START: begin
          if (decide_s && vote_q) begin
            state_d = IDLE;
          end else if (wrap_s) begin
            state_d = DATA;
          end else begin
            state_d = START;
          end
        end
        DATA: begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            shift_d[i] = (decide_s && (bit_q == 4'(i + 1))) ? vote_q : shift_q[i];
          end
          if (wrap_s && (bit_q == nbits_q)) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            state_d = DATA;
          end
        end
        PARITY: begin
          perr_d  = perr_q | (decide_s && (vote_q != expected_parity(shift_q, par_typ_q)));
          state_d = wrap_s ? STOP : PARITY;
        end
        STOP: begin
          serr_d  = serr_q | (decide_s & ~vote_q);
          state_d = (decide_s && (bit_q == last_bit_s)) ? IDLE : STOP;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      edge_q       <= '0;
      bit_q        <= 4'd0;
      samp_q       <= 2'b00;
      vote_q       <= 1'b0;
      presc_q      <= '0;
      nbits_q      <= 4'd0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      two_stop_q   <= 1'b0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      serr_q       <= 1'b0;
      rx_data_q    <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      edge_q       <= edge_d;
      bit_q        <= bit_d;
      samp_q       <= samp_d;
      vote_q       <= vote_d;
      presc_q      <= presc_d;
      nbits_q      <= nbits_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      two_stop_q   <= two_stop_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      serr_q       <= serr_d;
      rx_data_q    <= rx_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a pre-built line waveform is fed cycle by cycle and
// every output is compared with a frame-level model of the receiver.
module tb_uart_rx_ctrl;

  localparam int NC = 24000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  bit         line_a [NC];
  logic [5:0] cp_a   [NC];
  logic [3:0] cdb_a  [NC];
  bit         cpe_a  [NC];
  bit         cpt_a  [NC];
  bit         cts_a  [NC];

  bit         edv    [NC];
  bit         epe    [NC];
  bit         ese    [NC];
  bit         ebusy  [NC];
  logic [7:0] edata  [NC];

  int         gp;
  logic [5:0] cur_p;
  logic [3:0] cur_db;
  bit         cur_pe, cur_pt, cur_ts;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic put_cycle(input bit b);
    if (gp < NC) begin
      line_a[gp] = b;
      cp_a[gp]   = cur_p;
      cdb_a[gp]  = cur_db;
      cpe_a[gp]  = cur_pe;
      cpt_a[gp]  = cur_pt;
      cts_a[gp]  = cur_ts;
      gp++;
    end
  endtask

  task automatic put_level(input bit b, input int n);
    for (int i = 0; i < n; i++) put_cycle(b);
  endtask

  task automatic put_frame(input int p_raw, input int nb_raw, input bit pe, input bit pt,
                           input bit ts, input int data, input bit flip_par,
                           input bit stop0, input bit perturb, output int start);
    int p;
    int n;
    bit par;
    cur_p  = 6'(p_raw);
    cur_db = 4'(nb_raw);
    cur_pe = pe;
    cur_pt = pt;
    cur_ts = ts;
    p = (p_raw < 6) ? 6 : p_raw;
    n = (nb_raw < 5) ? 5 : ((nb_raw > 8) ? 8 : nb_raw);
    start = gp;
    par = pt ^ flip_par;
    put_level(1'b0, p);
    for (int k = 0; k < n; k++) begin
      put_level(data[k], p);
      par = par ^ data[k];
    end
    if (pe) put_level(par, p);
    put_level(!stop0, p);
    if (ts) put_level(1'b1, p);
    if (perturb) begin
      for (int i = start + 1; i < gp; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          cp_a[i]  = 6'($urandom_range(0, 40));
          cdb_a[i] = 4'($urandom_range(0, 15));
          cpe_a[i] = 1'($urandom_range(0, 1));
          cpt_a[i] = 1'($urandom_range(0, 1));
          cts_a[i] = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  // Majority of the three line samples around the middle of bit k.
  function automatic bit sample_bit(input int t0, input int k, input int p);
    int base;
    int s;
    base = t0 + k * p + p / 2;
    s = 0;
    for (int d = -1; d <= 1; d++) s += (base + d < NC) ? int'(line_a[base + d]) : 1;
    return s >= 2;
  endfunction

  task automatic run_model();
    int c;
    bit armed;
    logic [7:0] cur;
    c = 0;
    armed = 1'b0;
    cur = 8'h00;
    for (int i = 0; i < NC; i++) begin
      edv[i] = 1'b0; epe[i] = 1'b0; ese[i] = 1'b0; ebusy[i] = 1'b0; edata[i] = 8'h00;
    end
    while (c < NC) begin
      edata[c] = cur;
      if (line_a[c]) begin
        armed = 1'b1;
        c++;
      end else if (!armed) begin
        c++;
      end else begin
        int p, n, m, t0, last, tend;
        bit pe, pt, ts, perr, serr, glitch;
        logic [7:0] d;
        p  = (cp_a[c] < 6'd6) ? 6 : int'(cp_a[c]);
        n  = (cdb_a[c] < 4'd5) ? 5 : ((cdb_a[c] > 4'd8) ? 8 : int'(cdb_a[c]));
        pe = cpe_a[c]; pt = cpt_a[c]; ts = cts_a[c];
        armed = 1'b0;
        t0 = c + 1;
        m  = p / 2;
        perr = 1'b0; serr = 1'b0; d = 8'h00;
        glitch = sample_bit(t0, 0, p);
        if (glitch) begin
          tend = t0 + m + 2;
        end else begin
          last = n + int'(pe) + 1 + int'(ts);
          tend = t0 + last * p + m + 2;
          for (int k = 1; k <= n; k++) d[k-1] = sample_bit(t0, k, p);
          perr = pe && (sample_bit(t0, n + 1, p) != ((^d) ^ pt));
          for (int k = n + 1 + int'(pe); k <= last; k++) if (!sample_bit(t0, k, p)) serr = 1'b1;
        end
        for (int t = t0; t <= tend && t < NC; t++) begin
          ebusy[t] = 1'b1;
          edata[t] = cur;
        end
        if (!glitch && tend < NC) begin
          epe[tend] = perr;
          ese[tend] = serr;
          if (!perr && !serr) begin
            cur = d;
            edv[tend] = 1'b1;
            edata[tend] = cur;
          end
        end
        c = tend + 1;
      end
    end
  endtask

  task automatic drive(input int c);
    bus.rx_in     = line_a[c];
    bus.prescale  = cp_a[c];
    bus.data_bits = cdb_a[c];
    bus.par_en    = cpe_a[c];
    bus.par_typ   = cpt_a[c];
    bus.two_stop  = cts_a[c];
  endtask

  initial begin
    int s_a5, s_3c, s_3cf, s_gl, s_brk, s_11, s_b1, s_b2, s_cl, s_db, s_pe, dummy;
    bit ok;
    bit seen, err_seen;
    logic [7:0] got;
    logic [9:0] fr;

    gp = 0;
    cur_p = 6'd8; cur_db = 4'd8; cur_pe = 1'b0; cur_pt = 1'b0; cur_ts = 1'b0;

    put_level(1'b1, 20);
    put_frame(8, 8, 1'b0, 1'b0, 1'b0, 'hA5, 1'b0, 1'b0, 1'b0, s_a5);   put_level(1'b1, 6);
    put_frame(16, 7, 1'b1, 1'b1, 1'b1, 'h3C, 1'b0, 1'b0, 1'b0, s_3c);  put_level(1'b1, 5);
    put_frame(16, 7, 1'b1, 1'b1, 1'b1, 'h3C, 1'b1, 1'b0, 1'b0, s_3cf); put_level(1'b1, 10);
    s_gl = gp; put_level(1'b0, 2); put_level(1'b1, 30);
    put_frame(8, 8, 1'b0, 1'b0, 1'b0, 'h77, 1'b0, 1'b1, 1'b0, s_brk);
    put_level(1'b0, 40); put_level(1'b1, 10);
    put_frame(8, 8, 1'b0, 1'b0, 1'b0, 'h11, 1'b0, 1'b0, 1'b0, s_11);  put_level(1'b1, 5);
    put_frame(12, 8, 1'b0, 1'b0, 1'b0, 'h01, 1'b0, 1'b0, 1'b0, s_b1);
    put_frame(12, 8, 1'b0, 1'b0, 1'b0, 'hFE, 1'b0, 1'b0, 1'b0, s_b2);  put_level(1'b1, 8);
    put_frame(3, 8, 1'b0, 1'b0, 1'b0, 'hC3, 1'b0, 1'b0, 1'b0, s_cl);   put_level(1'b1, 8);
    put_frame(10, 12, 1'b0, 1'b0, 1'b0, 'h96, 1'b0, 1'b0, 1'b0, s_db); put_level(1'b1, 8);
    put_frame(10, 8, 1'b0, 1'b0, 1'b0, 'h5B, 1'b0, 1'b0, 1'b0, s_pe);
    for (int i = s_pe + 1; i < gp; i++) cpe_a[i] = 1'b1;
    put_level(1'b1, 8);

    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        put_level(1'b0, $urandom_range(1, 2));
        put_level(1'b1, 24);
      end
      put_frame($urandom_range(3, 20), $urandom_range(3, 12), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255),
                $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                1'($urandom_range(0, 1)), dummy);
      put_level(1'b1, $urandom_range(0, 4));
    end
    while (gp < NC) put_cycle(1'b1);

    run_model();

    // Hand-computed frame-end cycles pin the model.
    chk("pin_a5_dv",    int'(edv[s_a5 + 1 + 78]), 1);
    chk("pin_a5_data",  int'(edata[s_a5 + 1 + 78]), 'hA5);
    chk("pin_7o2_data", int'({edv[s_3c + 1 + 170], edata[s_3c + 1 + 170]}), 'h13C);
    chk("pin_7o2_perr", int'({epe[s_3cf + 1 + 170], edv[s_3cf + 1 + 170]}), 2);
    chk("pin_7o2_hold", int'(edata[s_3cf + 1 + 170]), 'h3C);
    chk("pin_glitch",   int'({ebusy[s_gl + 1 + 10], ebusy[s_gl + 1 + 11]}), 2);
    chk("pin_stop_err", int'({ese[s_brk + 1 + 78], edv[s_brk + 1 + 78]}), 2);
    chk("pin_after_brk", int'(edata[s_11 + 1 + 78]), 'h11);
    chk("pin_b2b_1",    int'(edata[s_b1 + 1 + 116]), 'h01);
    chk("pin_b2b_2",    int'({edv[s_b2 + 1 + 116], edata[s_b2 + 1 + 116]}), 'h1FE);
    chk("pin_clamp_p",  int'({edv[s_cl + 1 + 59], edata[s_cl + 1 + 59]}), 'h1C3);
    chk("pin_clamp_n",  int'({edv[s_db + 1 + 97], edata[s_db + 1 + 97]}), 'h196);
    chk("pin_par_latch", int'({edv[s_pe + 1 + 97], edata[s_pe + 1 + 97]}), 'h15B);

    drive(0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < NC; c++) begin
      #1;
      ok = (bus.data_valid === edv[c]) && (bus.par_err === epe[c]) && (bus.stp_err === ese[c]) &&
           (bus.busy === ebusy[c]) && (bus.rx_data === edata[c]);
      total++;
      if (!ok) begin
        bad++;
        if (bad <= 20)
          $display("FAIL cycle %0d: dv/pe/se/busy/data got %b%b%b%b %h want %b%b%b%b %h", c,
                   bus.data_valid, bus.par_err, bus.stp_err, bus.busy, bus.rx_data,
                   edv[c], epe[c], ese[c], ebusy[c], edata[c]);
      end
      @(posedge clk);
      #1;
      if (c + 1 < NC) drive(c + 1);
      @(negedge clk);
    end

    // Reset asserted in the middle of a frame.
    bus.prescale = 6'd16; bus.data_bits = 4'd8; bus.par_en = 1'b0; bus.two_stop = 1'b0;
    bus.rx_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.rx_in = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("busy_midframe", int'(bus.busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_data", int'(bus.rx_data), 0);
    chk("rst_pulses", int'({bus.data_valid, bus.par_err, bus.stp_err}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.rx_in = 1'b1;
    bus.prescale = 6'd8;
    repeat (4) @(posedge clk);
    seen = 1'b0; err_seen = 1'b0; got = 8'h00;
    fr = {1'b1, 8'h5A, 1'b0};
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          #1 bus.rx_in = fr[k];
          repeat (8) @(posedge clk);
        end
        #1 bus.rx_in = 1'b1;
      end
      begin
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk);
          if (bus.par_err || bus.stp_err) err_seen = 1'b1;
          if (bus.data_valid) begin
            seen = 1'b1;
            got = bus.rx_data;
          end
        end
      end
    join
    chk("post_rst_seen", int'(seen), 1);
    chk("post_rst_data", int'(got), 'h5A);
    chk("post_rst_err", int'(err_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
